// File: rtl/master_in_port.sv
// Serial-to-parallel receive port: accepts a burst on a valid/ready handshake,
// then shifts in LSB-first words back to back and pulses on each word and at frame end.
module master_in_port #(
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_en,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic                   slave_valid,
  input  logic                   rx_data,
  output logic                   master_ready,
  output logic [DATA_WIDTH-1:0]  dataout,
  output logic                   data_valid,
  output logic                   rx_done,
  output logic                   rx_busy,
  output logic [BURST_WIDTH-1:0] word_count
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  dataout_q, dataout_d;
  logic                   data_valid_q, data_valid_d;
  logic                   rx_done_q, rx_done_d;
  logic [BURST_WIDTH-1:0] word_count_q, word_count_d;
  logic [BURST_WIDTH-1:0] len_q, len_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    dataout_d    = dataout_q;
    data_valid_d = 1'b0;
    rx_done_d    = 1'b0;
    word_count_d = word_count_q;
    len_d        = len_q;
    case (state_q)
      IDLE: begin
        if (slave_valid && rx_en) begin
          len_d        = (burst_len == '0) ? BURST_WIDTH'(1) : burst_len;
          bit_cnt_d    = '0;
          word_count_d = '0;
          state_d      = RECEIVE;
        end
      end
      RECEIVE: begin
        shift_d[bit_cnt_q] = rx_data;
        bit_cnt_d          = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d    = '0;
          dataout_d    = shift_d;
          data_valid_d = 1'b1;
          word_count_d = word_count_q + BURST_WIDTH'(1);
          // Compare against the incremented count so the last word goes straight to DONE.
          if (word_count_d == len_q) state_d = DONE;
        end
      end
      DONE: begin
        rx_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      dataout_q    <= '0;
      data_valid_q <= 1'b0;
      rx_done_q    <= 1'b0;
      word_count_q <= '0;
      len_q        <= BURST_WIDTH'(1);
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      dataout_q    <= dataout_d;
      data_valid_q <= data_valid_d;
      rx_done_q    <= rx_done_d;
      word_count_q <= word_count_d;
      len_q        <= len_d;
    end
  end

  assign master_ready = (state_q == IDLE) && rx_en;
  assign rx_busy      = (state_q == RECEIVE) || (state_q == DONE);
  assign dataout      = dataout_q;
  assign data_valid   = data_valid_q;
  assign rx_done      = rx_done_q;
  assign word_count   = word_count_q;

endmodule

// File: doc/master_in_port.md
MASTER_IN_PORT -- requirements
Module: master_in_port

Interface
REQ-001 Parameter DATA_WIDTH, 8, bits per received word.
REQ-002 Parameter BURST_WIDTH, 12, width of the burst length and word counter.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 rx_en  in  1  master requests a read response; enables acceptance of a new frame.
REQ-006 burst_len  in  BURST_WIDTH  number of words in the frame; sampled at handshake; 0 is treated as 1.
REQ-007 slave_valid  in  1  slave has a response ready to send.
REQ-008 rx_data  in  1  serial data from the slave output port, LSB first, one bit per cycle.
REQ-009 master_ready  out  1  master can accept a frame; handshake = slave_valid & master_ready.
REQ-010 dataout  out  DATA_WIDTH  last fully received word.
REQ-011 data_valid  out  1  one-cycle pulse when dataout is updated.
REQ-012 rx_done  out  1  one-cycle pulse after the final word of a frame.
REQ-013 rx_busy  out  1  high while in RECEIVE or DONE.
REQ-014 word_count  out  BURST_WIDTH  words completed in the current or last frame.

Function
REQ-015 The FSM SHALL have states IDLE, RECEIVE, DONE, registered; unused encodings SHALL return to IDLE on the next edge.
REQ-016 master_ready SHALL equal rx_en in IDLE and 0 in RECEIVE and DONE (combinational from state and rx_en).
REQ-017 In IDLE on handshake at edge T: latch burst_len (0 becomes 1), clear bit_cnt and word_count, go to RECEIVE.
REQ-018 In IDLE without handshake: remain in IDLE; dataout and word_count SHALL hold.
REQ-019 In RECEIVE, bit k of word n SHALL be sampled at edge T+1+8n+k (k = 0..7, LSB first) into shift register position k.
REQ-020 At the edge sampling bit 7: dataout SHALL load the complete word, data_valid SHALL be 1 for the following cycle only, word_count SHALL increment, and bit_cnt SHALL wrap to 0.
REQ-021 If the completed word makes word_count equal to the latched length, next state SHALL be DONE; otherwise remain in RECEIVE with no idle cycle between words.
REQ-022 DONE SHALL last one cycle with rx_done = 1, then return to IDLE; a new handshake is accepted no earlier than the cycle after DONE.
REQ-023 slave_valid, rx_en and burst_len changes during RECEIVE/DONE SHALL be ignored.
REQ-024 word_count SHALL wrap modulo 2^BURST_WIDTH; a latched length of 4095 SHALL complete normally.
REQ-025 Frame latency: rx_done SHALL be high in the cycle after edge T+8N+1 for N words.

Reset
REQ-026 With reset = 0: state = IDLE, bit_cnt = 0, shift register = 0, dataout = 0, data_valid = 0, rx_done = 0, word_count = 0, latched length = 1.
REQ-027 Reset asserted mid-frame SHALL discard the partial word with no data_valid or rx_done pulse; after release, master_ready SHALL follow rx_en.

Verification
REQ-028 Single word: rx_en = 1, burst_len = 1, slave_valid pulse, bits of 8'hA5 LSB first -> dataout = 8'hA5, one data_valid pulse, rx_done one cycle later, word_count = 1.
REQ-029 Burst: burst_len = 3, words 8'h01, 8'hFF, 8'h3C back to back -> three data_valid pulses spaced 8 cycles apart with matching dataout, single rx_done, word_count = 3.
REQ-030 burst_len = 0 -> behaves as 1 word; rx_done after 8 bits.
REQ-031 rx_en = 0 with slave_valid = 1 -> master_ready = 0, no state change; then rx_en = 1 -> frame accepted on the first edge with both high.
REQ-032 Reset pulled low after 4 bits of a word -> all outputs at reset values, no pulses; subsequent 8'h5A frame is received correctly.
REQ-033 slave_valid held high through DONE -> a new frame starts only on the edge after DONE, and master_ready is 0 throughout RECEIVE.
